trace_decoder: RTL and testbench
================================

TRACE_DECODER -- requirements
Module: trace_decoder

Interface
REQ-001 Parameter: ERR_W, default 16, width of the error counter.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 valid  output  1  decoded trace record available.
REQ-005 ready  input  1  consumer accepts the record when valid && ready.
REQ-006 pc  output  64  decoded program counter.
REQ-007 inst  output  32  decoded instruction word.
REQ-008 jmp  output  1  decoded jump flag.
REQ-009 err_cnt  output  ERR_W  saturating count of malformed lines.
REQ-010 ar_addr  output  4  AXI-lite read address to the UART-lite.
REQ-011 ar_valid / ar_ready  output / input  1 each  AXI-lite read-address handshake.
REQ-012 r_data  input  32  AXI-lite read data.
REQ-013 r_valid / r_ready  input / output  1 each  AXI-lite read-data handshake; the block issues no writes.

Function
REQ-014 The block SHALL decode lines of exactly 28 chars: 16 hex pc digits (MSB first), space (0x20), 8 hex inst digits, space, 1 hex jmp digit ('0' or '1'), newline (0x0a).
REQ-015 Hex digits SHALL be accepted as 0-9, a-f and A-F; 0x0d SHALL be ignored at any position.
REQ-016 The FSM states SHALL be S_IDLE, S_STAT_REQ, S_STAT_RESP, S_DATA_REQ, S_DATA_RESP and S_EMIT; after reset S_IDLE SHALL go to S_STAT_REQ on the next cycle.
REQ-017 In S_STAT_REQ: ar_valid=1, ar_addr=4'h8; on ar_ready -> S_STAT_RESP.
REQ-018 In S_STAT_RESP: r_ready=1; on r_valid -> S_DATA_REQ if r_data[0] (RX valid), else -> S_STAT_REQ.
REQ-019 In S_DATA_REQ: ar_valid=1, ar_addr=4'h0; on ar_ready -> S_DATA_RESP.
REQ-020 In S_DATA_RESP: r_ready=1; on r_valid, r_data[7:0] SHALL be consumed as one char; if that char completes a good line -> S_EMIT, else -> S_STAT_REQ.
REQ-021 ar_valid and ar_addr SHALL stay stable until ar_ready; ar_valid and r_ready SHALL be 0 in all other states.
REQ-022 In S_EMIT: valid=1; on ready -> S_STAT_REQ; pc/inst/jmp SHALL be stable while valid && !ready.
REQ-023 Latency: valid SHALL rise the cycle after the r_valid beat that carries the final newline.
REQ-024 pc/inst/jmp SHALL update only when entering S_EMIT; partial fields SHALL be held in shadow registers.
REQ-025 A bad char for the current position, a jmp digit above 1, or a line longer than 28 chars SHALL increment err_cnt and put the parser in discard mode until the next newline, after which the position SHALL return to 0.
REQ-026 A newline at a position other than 27 SHALL increment err_cnt and return the position to 0 directly.
REQ-027 err_cnt SHALL saturate at all-ones; it SHALL never wrap.
REQ-028 No AXI read SHALL be issued while in S_EMIT, so consumer backpressure stalls the UART polling.

Reset
REQ-029 On rstn low: state=S_IDLE, valid=0, ar_valid=0, r_ready=0, ar_addr=0, pc=0, inst=0, jmp=0, err_cnt=0, parser position=0, discard mode=0.
REQ-030 Reset mid-line or mid-transaction SHALL discard the partial line and any outstanding handshake; after reset the block SHALL restart with a status read.

Structure
REQ-031 A shared package trace_pkg SHALL hold the state enum, LINE_LEN=28, the field offsets (0, 16, 17, 25, 26, 27), the UART register addresses (RX=4'h0, STAT=4'h8), the RX-valid status bit index (0), and the ASCII-to-nibble decode function.
REQ-032 The block SHALL have one sub-module, trace_line_parser, which takes a char strobe and a byte and produces a line-done pulse, an error pulse and the pc/inst/jmp shadow fields; the AXI FSM and output registers SHALL stay in trace_decoder.

Verification
REQ-033 "0000000080000000 00000013 0\n" fed through the UART model -> one record with pc=0x80000000, inst=0x00000013, jmp=0, err_cnt=0.
REQ-034 "FFFFFFFFFFFFFFFF DEADBEEF 1\r\n" -> pc=0xFFFFFFFFFFFFFFFF, inst=0xDEADBEEF, jmp=1.
REQ-035 'g' at pc position 3, then a good line -> err_cnt=1 and exactly one record (the second line).
REQ-036 "1234\n", then a good line -> err_cnt=1, no record for the short line, second line decoded correctly.
REQ-037 ready held low for 20 cycles -> valid held at 1, outputs stable, ar_valid=0 throughout; after ready=1, polling resumes at ar_addr=4'h8.
REQ-038 Status r_data[0]=0 for 50 polls -> no read at ar_addr=4'h0; rstn pulsed low after 10 chars of a line -> outputs reset to 0 and the next complete line decodes with err_cnt=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types, constants and the ASCII hex decoder for the UART trace-line decoder.
package trace_pkg;

    localparam int LINE_LEN = 28;
    localparam int POS_W    = 5;

    localparam logic [POS_W-1:0] OFF_PC   = 5'd0;
    localparam logic [POS_W-1:0] OFF_SP0  = 5'd16;
    localparam logic [POS_W-1:0] OFF_INST = 5'd17;
    localparam logic [POS_W-1:0] OFF_SP1  = 5'd25;
    localparam logic [POS_W-1:0] OFF_JMP  = 5'd26;
    localparam logic [POS_W-1:0] OFF_NL   = 5'd27;

    localparam logic [3:0] UART_RX_ADDR   = 4'h0;
    localparam logic [3:0] UART_STAT_ADDR = 4'h8;
    localparam int         STAT_RX_VALID_BIT = 0;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_NL    = 8'h0a;
    localparam logic [7:0] CH_CR    = 8'h0d;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_ONE   = 8'h31;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_STAT_REQ  = 3'd1;
    localparam state_t S_STAT_RESP = 3'd2;
    localparam state_t S_DATA_REQ  = 3'd3;
    localparam state_t S_DATA_RESP = 3'd4;
    localparam state_t S_EMIT      = 3'd5;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        jmp;
    } trace_rec_t;

    // Returns {is_hex, nibble}; letters of either case map to 10..15.
    function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

endpackage

// File: rtl/trace_line_parser.sv
// Character-level parser for "<16 hex> <8 hex> <0|1>\n" trace lines; builds the
// pc/inst/jmp shadow fields and flags line completion or malformed input.
module trace_line_parser
    import trace_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        char_stb_i,
    input  logic [7:0]  char_i,
    output logic        line_done_o,
    output logic        err_o,
    output trace_rec_t  fields_o
);

    logic [POS_W-1:0] pos_q, pos_d;
    logic             disc_q, disc_d;
    logic [63:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic             jmp_q, jmp_d;

    logic [4:0] hex;
    logic       is_nl;
    logic       is_cr;
    logic       char_ok;

    assign hex   = hex_to_nibble(char_i);
    assign is_nl = (char_i == CH_NL);
    assign is_cr = (char_i == CH_CR);

    // Position OFF_NL only accepts a newline, so any other char there is an overlong line.
    always_comb begin
        char_ok = 1'b0;
        if (pos_q < OFF_SP0) begin
            char_ok = hex[4];
        end else if (pos_q == OFF_SP0 || pos_q == OFF_SP1) begin
            char_ok = (char_i == CH_SPACE);
        end else if (pos_q >= OFF_INST && pos_q < OFF_SP1) begin
            char_ok = hex[4];
        end else if (pos_q == OFF_JMP) begin
            char_ok = (char_i == CH_ZERO) || (char_i == CH_ONE);
        end
    end

    always_comb begin
        pos_d       = pos_q;
        disc_d      = disc_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        jmp_d       = jmp_q;
        line_done_o = 1'b0;
        err_o       = 1'b0;
        if (char_stb_i && !is_cr) begin
            if (is_nl) begin
                pos_d  = '0;
                disc_d = 1'b0;
                if (!disc_q) begin
                    if (pos_q == OFF_NL) begin
                        line_done_o = 1'b1;
                    end else begin
                        err_o = 1'b1;
                    end
                end
            end else if (!disc_q) begin
                if (char_ok) begin
                    pos_d = pos_q + 5'd1;
                    if (pos_q < OFF_SP0) begin
                        pc_d = {pc_q[59:0], hex[3:0]};
                    end else if (pos_q >= OFF_INST && pos_q < OFF_SP1) begin
                        inst_d = {inst_q[27:0], hex[3:0]};
                    end else if (pos_q == OFF_JMP) begin
                        jmp_d = char_i[0];
                    end
                end else begin
                    err_o  = 1'b1;
                    disc_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pos_q  <= '0;
            disc_q <= 1'b0;
            pc_q   <= '0;
            inst_q <= '0;
            jmp_q  <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            disc_q <= disc_d;
            pc_q   <= pc_d;
            inst_q <= inst_d;
            jmp_q  <= jmp_d;
        end
    end

    assign fields_o = '{pc: pc_q, inst: inst_q, jmp: jmp_q};

endmodule

// File: rtl/trace_decoder.sv
// Polls a UART-lite over AXI-lite reads, decodes trace lines and presents one
// pc/inst/jmp record at a time with valid/ready backpressure.
//
// state        | meaning
// S_IDLE       | one cycle after reset before polling starts
// S_STAT_REQ   | read address for the status register
// S_STAT_RESP  | wait for status data, check RX-valid
// S_DATA_REQ   | read address for the RX FIFO
// S_DATA_RESP  | wait for RX data, feed one char to the parser
// S_EMIT       | record presented, polling stalled until consumed
module trace_decoder
    import trace_pkg::*;
#(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             valid,
    input  logic             ready,
    output logic [63:0]      pc,
    output logic [31:0]      inst,
    output logic             jmp,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       ar_addr,
    output logic             ar_valid,
    input  logic             ar_ready,
    input  logic [31:0]      r_data,
    input  logic             r_valid,
    output logic             r_ready
);

    state_t           state_q, state_d;
    trace_rec_t       rec_q, rec_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic       char_stb;
    logic       line_done;
    logic       line_err;
    trace_rec_t shadow;
    logic       unused_rdata;

    assign char_stb     = (state_q == S_DATA_RESP) && r_valid;
    assign unused_rdata = ^r_data[31:8];

    trace_line_parser u_parser (
        .clk         (clk),
        .rstn        (rstn),
        .char_stb_i  (char_stb),
        .char_i      (r_data[7:0]),
        .line_done_o (line_done),
        .err_o       (line_err),
        .fields_o    (shadow)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = S_STAT_REQ;
            S_STAT_REQ:  if (ar_ready) state_d = S_STAT_RESP;
            S_STAT_RESP: begin
                if (r_valid) begin
                    state_d = r_data[STAT_RX_VALID_BIT] ? S_DATA_REQ : S_STAT_REQ;
                end
            end
            S_DATA_REQ:  if (ar_ready) state_d = S_DATA_RESP;
            S_DATA_RESP: begin
                if (r_valid) begin
                    state_d = line_done ? S_EMIT : S_STAT_REQ;
                end
            end
            S_EMIT:      if (ready) state_d = S_STAT_REQ;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output record is loaded only on the transition into S_EMIT.
    always_comb begin
        rec_d = rec_q;
        if (char_stb && line_done) begin
            rec_d = shadow;
        end
        err_d = err_q;
        if (line_err && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            rec_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            rec_q   <= rec_d;
            err_q   <= err_d;
        end
    end

    assign valid    = (state_q == S_EMIT);
    assign ar_valid = (state_q == S_STAT_REQ) || (state_q == S_DATA_REQ);
    assign ar_addr  = (state_q == S_STAT_REQ) ? UART_STAT_ADDR : UART_RX_ADDR;
    assign r_ready  = (state_q == S_STAT_RESP) || (state_q == S_DATA_RESP);
    assign pc       = rec_q.pc;
    assign inst     = rec_q.inst;
    assign jmp      = rec_q.jmp;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_trace_decoder.sv
// Bench for trace_decoder: UART-lite slave model, consumer, and a line-level reference model.
module tb_trace_decoder;

    localparam int EW      = 3;
    localparam int ERR_MAX = (1 << EW) - 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        jmp;
    } rec_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          ready = 1'b0;
    logic          valid;
    logic [63:0]   pc;
    logic [31:0]   inst;
    logic          jmp;
    logic [EW-1:0] err_cnt;
    logic [3:0]    ar_addr;
    logic          ar_valid;
    logic          ar_ready = 1'b0;
    logic [31:0]   r_data = 32'h0;
    logic          r_valid = 1'b0;
    logic          r_ready;

    trace_decoder #(.ERR_W(EW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .valid    (valid),
        .ready    (ready),
        .pc       (pc),
        .inst     (inst),
        .jmp      (jmp),
        .err_cnt  (err_cnt),
        .ar_addr  (ar_addr),
        .ar_valid (ar_valid),
        .ar_ready (ar_ready),
        .r_data   (r_data),
        .r_valid  (r_valid),
        .r_ready  (r_ready)
    );

    always #5 clk = ~clk;

    byte unsigned chr_q[$];
    byte unsigned cur_line[$];
    byte unsigned lbuf[$];
    rec_t         rec_q[$];
    rec_t         exp_q[$];
    int           exp_err = 0;
    int           checks = 0;
    int           failures = 0;
    int           stat_reads = 0;
    int           data_reads = 0;
    int           proto_viol = 0;
    int           stab_viol = 0;
    bit           force_empty = 1'b0;
    int           ready_mode = 0;

    // UART-lite slave: status bit 0 reports a pending char, RX reads pop one char.
    initial begin : axi_slave
        bit ar_hs, r_hs, rd_pend, arv_wait;
        logic [3:0] hs_addr, rd_addr, wait_addr;
        int rd_dly;
        byte unsigned ch;
        ar_hs = 0; r_hs = 0; rd_pend = 0; arv_wait = 0;
        hs_addr = '0; rd_addr = '0; wait_addr = '0; rd_dly = 0; ch = 8'h00;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                ar_hs = 0; r_hs = 0; rd_pend = 0; arv_wait = 0;
                ar_ready = 1'b0; r_valid = 1'b0;
            end else begin
                if (arv_wait && (!ar_valid || ar_addr !== wait_addr)) proto_viol++;
                if (ar_valid && r_ready) proto_viol++;
                if (ar_hs) begin
                    rd_pend = 1; rd_addr = hs_addr; rd_dly = $urandom_range(0, 2);
                end
                if (r_hs) begin
                    rd_pend = 0; r_valid = 1'b0;
                end
                ar_ready = !rd_pend && ($urandom_range(0, 2) != 0);
                if (rd_pend && !r_valid) begin
                    if (rd_dly > 0) begin
                        rd_dly--;
                    end else begin
                        r_valid = 1'b1;
                        if (rd_addr == 4'h8) begin
                            stat_reads++;
                            r_data = ($urandom & 32'hFFFF_FFFE) |
                                     32'((chr_q.size() > 0) && !force_empty);
                        end else begin
                            data_reads++;
                            if (chr_q.size() > 0) ch = chr_q.pop_front();
                            else ch = 8'h00;
                            r_data = {24'($urandom), ch};
                        end
                    end
                end
                ar_hs = ar_valid && ar_ready; hs_addr = ar_addr;
                r_hs = r_valid && r_ready;
                arv_wait = ar_valid && !ar_ready; wait_addr = ar_addr;
            end
        end
    end

    // Consumer: drives ready, captures accepted records, watches hold stability.
    initial begin : consumer
        bit hs, hold;
        rec_t snap;
        hs = 0; hold = 0; snap = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                hs = 0; hold = 0; ready = 1'b0;
            end else begin
                if (hs) rec_q.push_back(snap);
                if (hold && (!valid || {pc, inst, jmp} !== snap)) stab_viol++;
                if (valid && (ar_valid || r_ready)) proto_viol++;
                if (ready_mode == 2) ready = 1'b1;
                else if (ready_mode == 1) ready = 1'b0;
                else ready = 1'($urandom_range(0, 1));
                snap = {pc, inst, jmp};
                hs = valid && ready;
                hold = valid && !ready;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int hexv(input byte unsigned c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 8'h30;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 8'h61 + 10;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 8'h41 + 10;
        return -1;
    endfunction

    // A line (CRs removed, newline excluded) is good only if it is exactly
    // 16 hex, space, 8 hex, space, '0'/'1'; every other line costs one error.
    task automatic model_line;
        bit ok;
        rec_t r;
        int v;
        ok = (cur_line.size() == 27);
        r = '0;
        if (ok) begin
            for (int i = 0; i < 27; i++) begin
                if (i == 16 || i == 25) begin
                    if (cur_line[i] != 8'h20) ok = 0;
                end else if (i == 26) begin
                    if (cur_line[i] != 8'h30 && cur_line[i] != 8'h31) ok = 0;
                end else begin
                    v = hexv(cur_line[i]);
                    if (v < 0) ok = 0;
                    else if (i < 16) r.pc = r.pc * 16 + 64'(v);
                    else r.inst = r.inst * 16 + 32'(v);
                end
            end
        end
        if (ok) begin
            r.jmp = (cur_line[26] == 8'h31);
            exp_q.push_back(r);
        end else if (exp_err < ERR_MAX) begin
            exp_err++;
        end
    endtask

    task automatic push_byte(input byte unsigned c);
        chr_q.push_back(c);
        if (c == 8'h0d) return;
        if (c != 8'h0a) begin
            cur_line.push_back(c);
            return;
        end
        model_line();
        cur_line.delete();
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) push_byte(s[i]);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (chr_q.size() != 0 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        repeat (60) @(negedge clk);
        checks++;
        if (chr_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d chars left, required 0", tag, chr_q.size());
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chr_q.delete(); cur_line.delete(); exp_q.delete(); rec_q.delete();
        exp_err = 0;
        force_empty = 1'b0;
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (valid !== 1'b0 || ar_valid !== 1'b0 || r_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: valid=%b ar_valid=%b r_ready=%b, required 0 0 0", valid, ar_valid, r_ready);
        end
        if (ar_addr !== 4'h0) begin
            failures++; $display("FAIL reset_ar_addr: got %h, required 0", ar_addr);
        end
        if (pc !== 64'h0 || inst !== 32'h0) begin
            failures++; $display("FAIL reset_pc_inst: got %h %h, required 0 0", pc, inst);
        end
        if (jmp !== 1'b0) begin
            failures++; $display("FAIL reset_jmp: got %b, required 0", jmp);
        end
        if (err_cnt !== '0) begin
            failures++; $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt);
        end
        rstn = 1'b1;
        #1;
        checks++;
        if (ar_valid !== 1'b0) begin
            failures++; $display("FAIL reset_idle: ar_valid=%b in idle cycle, required 0", ar_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ar_valid !== 1'b1 || ar_addr !== 4'h8) begin
            failures++;
            $display("FAIL reset_first_poll: ar_valid=%b ar_addr=%h, required 1 8", ar_valid, ar_addr);
        end
    endtask

    task automatic test_basic;
        ready_mode = 0;
        push_str("0000000080000000 00000013 0\n");
        wait_drain("basic");
        checks += 2;
        if (rec_q.size() != 1) begin
            failures++; $display("FAIL basic_count: got %0d records, required 1", rec_q.size());
        end else if (rec_q[0] !== {64'h80000000, 32'h00000013, 1'b0}) begin
            failures++;
            $display("FAIL basic_rec: got pc=%h inst=%h jmp=%b, required 80000000 00000013 0",
                     rec_q[0].pc, rec_q[0].inst, rec_q[0].jmp);
        end
        if (err_cnt !== '0) begin
            failures++; $display("FAIL basic_err: got %0d, required 0", err_cnt);
        end
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_crlf;
        push_str("FFFFFFFFFFFFFFFF DEADBEEF 1\r\n");
        wait_drain("crlf");
        checks++;
        if (rec_q.size() != 1 || rec_q[0] !== {64'hFFFFFFFFFFFFFFFF, 32'hDEADBEEF, 1'b1}) begin
            failures++;
            $display("FAIL crlf_rec: got %0d records first=%h, required 1 record ffffffffffffffff deadbeef 1",
                     rec_q.size(), (rec_q.size() > 0) ? rec_q[0] : rec_t'(0));
        end
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_bad_char;
        do_reset();
        push_str("000g000080000000 00000013 0\n");
        push_str("0000000000001000 00a00093 1\n");
        wait_drain("bad_char");
        checks += 2;
        if (err_cnt !== 3'd1) begin
            failures++; $display("FAIL bad_char_err: got %0d, required 1", err_cnt);
        end
        if (rec_q.size() != 1 || rec_q[0] !== {64'h1000, 32'h00a00093, 1'b1}) begin
            failures++;
            $display("FAIL bad_char_rec: got %0d records, required 1 with pc=1000 inst=00a00093 jmp=1", rec_q.size());
        end
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_short;
        do_reset();
        push_str("1234\n");
        push_str("00000000DEADBEEF cafef00d 0\n");
        wait_drain("short");
        checks += 2;
        if (err_cnt !== 3'd1) begin
            failures++; $display("FAIL short_err: got %0d, required 1", err_cnt);
        end
        if (rec_q.size() != 1 || rec_q[0] !== {64'hDEADBEEF, 32'hCAFEF00D, 1'b0}) begin
            failures++;
            $display("FAIL short_rec: got %0d records, required 1 with pc=deadbeef inst=cafef00d jmp=0", rec_q.size());
        end
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure;
        int n;
        bit bad_v, bad_ar, bad_f;
        ready_mode = 1;
        push_str("0123456789ABCDEF 76543210 1\n");
        n = 0;
        while (!valid && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!valid) begin
            failures++; $display("FAIL bp_valid_timeout: valid=%b, required 1", valid);
        end
        bad_v = 0; bad_ar = 0; bad_f = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid !== 1'b1) bad_v = 1;
            if (ar_valid !== 1'b0) bad_ar = 1;
            if ({pc, inst, jmp} !== {64'h0123456789ABCDEF, 32'h76543210, 1'b1}) bad_f = 1;
        end
        checks += 3;
        if (bad_v) begin
            failures++; $display("FAIL bp_hold_valid: dropped to 0, required 1 for 20 cycles");
        end
        if (bad_ar) begin
            failures++; $display("FAIL bp_hold_ar_valid: saw 1, required 0 while stalled");
        end
        if (bad_f) begin
            failures++; $display("FAIL bp_hold_fields: got %h %h %b, required 0123456789abcdef 76543210 1", pc, inst, jmp);
        end
        ready_mode = 2;
        n = 0;
        while (valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (valid !== 1'b0 || ar_valid !== 1'b1 || ar_addr !== 4'h8) begin
            failures++;
            $display("FAIL bp_resume: valid=%b ar_valid=%b ar_addr=%h, required 0 1 8", valid, ar_valid, ar_addr);
        end
        ready_mode = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (rec_q.size() != 1) begin
            failures++; $display("FAIL bp_count: got %0d records, required 1", rec_q.size());
        end
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_no_rx;
        int s0, d0, n;
        force_empty = 1'b1;
        push_str("00000000000000AA 000000BB 0\n");
        s0 = stat_reads; d0 = data_reads; n = 0;
        while (stat_reads < s0 + 50 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks += 2;
        if (stat_reads < s0 + 50) begin
            failures++; $display("FAIL no_rx_polls: got %0d status polls, required 50", stat_reads - s0);
        end
        if (data_reads != d0) begin
            failures++; $display("FAIL no_rx_data_reads: got %0d, required 0", data_reads - d0);
        end
        force_empty = 1'b0;
        wait_drain("no_rx");
        checks++;
        if (rec_q.size() != 1 || rec_q[0] !== {64'hAA, 32'hBB, 1'b0}) begin
            failures++; $display("FAIL no_rx_rec: got %0d records, required 1 with pc=aa inst=bb", rec_q.size());
        end
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid;
        int d0, n;
        push_str("0123456789abcdef 89abcdef 1\n");
        d0 = data_reads; n = 0;
        while (data_reads < d0 + 10 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        rstn = 1'b0;
        #1;
        checks += 2;
        if (valid !== 1'b0 || ar_valid !== 1'b0 || r_ready !== 1'b0 || err_cnt !== '0) begin
            failures++;
            $display("FAIL mid_reset_ctl: valid=%b ar_valid=%b r_ready=%b err_cnt=%0d, required 0 0 0 0",
                     valid, ar_valid, r_ready, err_cnt);
        end
        if (pc !== 64'h0 || inst !== 32'h0 || jmp !== 1'b0) begin
            failures++; $display("FAIL mid_reset_rec: got %h %h %b, required 0 0 0", pc, inst, jmp);
        end
        do_reset();
        push_str("FEDCBA9876543210 0badf00d 0\n");
        wait_drain("reset_mid");
        checks += 2;
        if (rec_q.size() != 1 || rec_q[0] !== {64'hFEDCBA9876543210, 32'h0BADF00D, 1'b0}) begin
            failures++; $display("FAIL mid_reset_next: got %0d records, required 1 with pc=fedcba9876543210", rec_q.size());
        end
        if (err_cnt !== '0) begin
            failures++; $display("FAIL mid_reset_err: got %0d, required 0", err_cnt);
        end
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturate;
        do_reset();
        repeat (6) push_str("\n");
        push_str("x\n");
        wait_drain("sat1");
        checks++;
        if (err_cnt !== 3'd7) begin
            failures++; $display("FAIL sat_reach: got %0d, required 7", err_cnt);
        end
        repeat (3) push_str("\n");
        push_str("12 34\n");
        wait_drain("sat2");
        checks += 2;
        if (err_cnt !== 3'd7) begin
            failures++; $display("FAIL sat_hold: got %0d, required 7", err_cnt);
        end
        if (rec_q.size() != 0) begin
            failures++; $display("FAIL sat_records: got %0d, required 0", rec_q.size());
        end
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_random;
        for (int b = 0; b < 4; b++) begin
            do_reset();
            ready_mode = 0;
            for (int l = 0; l < 6; l++) begin
                logic [63:0] rpc;
                logic [31:0] rinst;
                int          rj, kind, p;
                string       s;
                rpc   = {$urandom, $urandom};
                rinst = $urandom;
                rj    = $urandom_range(0, 1);
                s = $sformatf("%016h %08h %0d", rpc, rinst, rj);
                if ($urandom_range(0, 1) == 1) s = s.toupper();
                lbuf.delete();
                for (int i = 0; i < s.len(); i++) lbuf.push_back(s[i]);
                kind = $urandom_range(0, 6);
                if (kind == 3) begin
                    p = $urandom_range(0, 26);
                    if (p == 16 || p == 25) lbuf[p] = 8'h30;
                    else if (p == 26) lbuf[p] = 8'($urandom_range(8'h32, 8'h39));
                    else lbuf[p] = 8'h67;
                end else if (kind == 4) begin
                    p = $urandom_range(0, 26);
                    while (lbuf.size() > p) void'(lbuf.pop_back());
                end else if (kind == 5) begin
                    lbuf.push_back(8'h61);
                end
                if ($urandom_range(0, 3) == 0) lbuf.insert($urandom_range(0, lbuf.size()), 8'h0d);
                lbuf.push_back(8'h0a);
                foreach (lbuf[i]) push_byte(lbuf[i]);
            end
            wait_drain("random");
            checks++;
            if (rec_q.size() != exp_q.size()) begin
                failures++;
                $display("FAIL random_count batch %0d: got %0d records, required %0d", b, rec_q.size(), exp_q.size());
            end else begin
                foreach (rec_q[i]) begin
                    checks++;
                    if (rec_q[i] !== exp_q[i]) begin
                        failures++;
                        $display("FAIL random_rec batch %0d idx %0d: got %h, required %h", b, i, rec_q[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if (err_cnt !== EW'(exp_err)) begin
                failures++; $display("FAIL random_err batch %0d: got %0d, required %0d", b, err_cnt, exp_err);
            end
            rec_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_protocol;
        checks += 2;
        if (proto_viol != 0) begin
            failures++; $display("FAIL axi_protocol: got %0d violations, required 0", proto_viol);
        end
        if (stab_viol != 0) begin
            failures++; $display("FAIL output_stability: got %0d violations, required 0", stab_viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crlf();
        test_bad_char();
        test_short();
        test_backpressure();
        test_no_rx();
        test_reset_mid();
        test_saturate();
        test_random();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
